// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read data.
module sync_fifo_flags #(
  parameter int DSIZE         = 8,
  parameter int ASIZE         = 4,
  parameter int AFULL_THRESH  = 2**ASIZE - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int             DEPTH    = 2**ASIZE;
  localparam logic [ASIZE:0] PTR_ONE  = {{ASIZE{1'b0}}, 1'b1};
  localparam logic [ASIZE:0] AFULL_L  = (ASIZE+1)'(AFULL_THRESH);
  localparam logic [ASIZE:0] AEMPTY_L = (ASIZE+1)'(AEMPTY_THRESH);

  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_afull_chk
    $error("sync_fifo_flags: AFULL_THRESH out of range 1..2**ASIZE");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_aempty_chk
    $error("sync_fifo_flags: AEMPTY_THRESH out of range 0..2**ASIZE-1");
  end

  logic [DSIZE-1:0] mem [0:DEPTH-1];

  logic [ASIZE:0] wptr_q, wptr_d, rptr_q, rptr_d, cnt_q, cnt_d;
  logic           wfull_q, wfull_d, rempty_q, rempty_d;
  logic           afull_q, afull_d, aempty_q, aempty_d;
  logic           ovf_q, ovf_d, unf_q, unf_d;
  logic           we, re;
  logic [ASIZE-1:0] waddr, raddr;

  assign waddr = wptr_q[ASIZE-1:0];
  assign raddr = rptr_q[ASIZE-1:0];

  // Flags are computed from the post-edge pointers so they are current right after each edge.
  always_comb begin
    we     = winc & ~wfull_q;
    re     = rinc & ~rempty_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (we) wptr_d = wptr_q + PTR_ONE;
    if (re) rptr_d = rptr_q + PTR_ONE;
    case ({we, re})
      2'b10:   cnt_d = cnt_q + PTR_ONE;
      2'b01:   cnt_d = cnt_q - PTR_ONE;
      default: cnt_d = cnt_q;
    endcase
    wfull_d  = (wptr_d == {~rptr_d[ASIZE], rptr_d[ASIZE-1:0]});
    rempty_d = (wptr_d == rptr_d);
    afull_d  = (cnt_d >= AFULL_L);
    aempty_d = (cnt_d <= AEMPTY_L);
    ovf_d    = ovf_q | (winc & wfull_q);
    unf_d    = unf_q | (rinc & rempty_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  always_comb begin
    rdata = '0;
    if (!rempty_q) rdata = mem[raddr];
  end
`else
  logic [DSIZE-1:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;
`endif

  assign wfull         = wfull_q;
  assign rempty        = rempty_q;
  assign walmost_full  = afull_q;
  assign ralmost_empty = aempty_q;
  assign count         = cnt_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: directed and random traffic compared against a queue-based model.
module tb_sync_fifo_flags;

  logic       clk;
  logic       rst;
  logic [7:0] wdata;
  logic       winc;
  logic       rinc;
  logic [7:0] rdata;
  logic       wfull;
  logic       rempty;
  logic       walmost_full;
  logic       ralmost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  sync_fifo_flags #(
    .DSIZE(8), .ASIZE(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2)
  ) dut (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc),
    .rdata(rdata), .wfull(wfull), .rempty(rempty),
    .walmost_full(walmost_full), .ralmost_empty(ralmost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents as a queue, sticky errors, last word handed out.
  logic [7:0] q[$];
  logic       ovf_m;
  logic       unf_m;
  logic [7:0] exp_rd;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ":count"},         32'(count),         32'(n));
    check({tag, ":wfull"},         32'(wfull),         32'(n == 16));
    check({tag, ":rempty"},        32'(rempty),        32'(n == 0));
    check({tag, ":walmost_full"},  32'(walmost_full),  32'(n >= 14));
    check({tag, ":ralmost_empty"}, 32'(ralmost_empty), 32'(n <= 2));
    check({tag, ":overflow"},      32'(overflow),      32'(ovf_m));
    check({tag, ":underflow"},     32'(underflow),     32'(unf_m));
`ifdef SYNC_FIFO_FWFT_EN
    if (n != 0) check({tag, ":rdata_head"}, 32'(rdata), 32'(q[0]));
`else
    check({tag, ":rdata"}, 32'(rdata), 32'(exp_rd));
`endif
  endtask

  task automatic model_clear();
    q.delete();
    ovf_m  = 1'b0;
    unf_m  = 1'b0;
    exp_rd = 8'h00;
  endtask

  // One clock with the given requests, then model update and full comparison.
  task automatic cyc(input string tag, input logic w, input logic r, input logic [7:0] d);
    int  n;
    logic full, empty;
    winc  = w;
    rinc  = r;
    wdata = d;
    @(posedge clk);
    #1;
    n     = q.size();
    full  = (n == 16);
    empty = (n == 0);
    if (w && full)  ovf_m = 1'b1;
    if (r && empty) unf_m = 1'b1;
    if (r && !empty) exp_rd = q.pop_front();
    if (w && !full) q.push_back(d);
    winc = 1'b0;
    rinc = 1'b0;
    check_all(tag);
  endtask

  // Asynchronous reset, checked before any clock edge sees it.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check_all(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = 8'h00;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    rst = 1'b0;

    // Reset mid-stream with five words held and non-zero read data.
    for (int i = 0; i < 6; i++) cyc("pre", 1'b1, 1'b0, 8'(8'h40 + i));
    cyc("pre_rd", 1'b0, 1'b1, 8'h00);
    do_reset("midrst");
    cyc("a5_wr", 1'b1, 1'b0, 8'hA5);
    cyc("a5_rd", 1'b0, 1'b1, 8'h00);
    check("a5_val", 32'(exp_rd), 32'h0000_00A5);

    // Fill and drain, then overflow and underflow on the boundaries.
    do_reset("rst_fill");
    for (int i = 0; i < 16; i++) cyc("fill", 1'b1, 1'b0, 8'(i));
    cyc("ovf", 1'b1, 1'b0, 8'hFF);
    cyc("ovf_hold", 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) cyc("drain", 1'b0, 1'b1, 8'h00);
    cyc("unf", 1'b0, 1'b1, 8'h00);
    cyc("unf_hold", 1'b0, 1'b0, 8'h00);

    // Simultaneous access while full, while empty, and at half occupancy.
    do_reset("rst_sim");
    for (int i = 0; i < 16; i++) cyc("sim_fill", 1'b1, 1'b0, 8'(8'h80 + i));
    cyc("sim_full", 1'b1, 1'b1, 8'hEE);
    for (int i = 0; i < 15; i++) cyc("sim_drain", 1'b0, 1'b1, 8'h00);
    cyc("sim_empty", 1'b1, 1'b1, 8'h3C);
    cyc("sim_3c", 1'b0, 1'b1, 8'h00);
    do_reset("rst_mid");
    for (int i = 0; i < 8; i++) cyc("mid_fill", 1'b1, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 20; i++) cyc("mid_rw", 1'b1, 1'b1, 8'(8'h20 + i));
    for (int i = 0; i < 8; i++) cyc("mid_drain", 1'b0, 1'b1, 8'h00);

    // Interleaved traffic long enough for both pointers to wrap.
    do_reset("rst_wrap");
    for (int i = 0; i < 40; i++) cyc("wrap", 1'b1, (i >= 3), 8'(i));
    for (int i = 0; i < 3; i++) cyc("wrap_tail", 1'b0, 1'b1, 8'h00);

    // Head-word sequence (shows fall-through when that mode is built in).
    do_reset("rst_head");
    cyc("head_11", 1'b1, 1'b0, 8'h11);
    cyc("head_22", 1'b1, 1'b0, 8'h22);
    cyc("head_pop1", 1'b0, 1'b1, 8'h00);
    cyc("head_pop2", 1'b0, 1'b1, 8'h00);

    // Random traffic, with an occasional burst bias so both ends get reached.
    do_reset("rst_rand");
    for (int i = 0; i < 400; i++) begin
      logic w, r;
      int   bias;
      bias = ((i / 50) % 2 == 0) ? 75 : 25;
      w = ($urandom_range(0, 99) < bias);
      r = ($urandom_range(0, 99) >= bias);
      if ($urandom_range(0, 9) == 0) begin
        w = 1'b1;
        r = 1'b1;
      end
      cyc("rand", w, r, 8'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
